// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the alu_multiplex arbiter: FSM states, requester count, select width.
package alu_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        VALID = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/alu_mux_arbiter_rr_pick.sv
// Combinational winner search: first asserted request at or above ptr, wrapping modulo N_REQ.
module rr_pick
    import alu_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // rot[k] is the request that sits k places above the pointer
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] idx;
            assign idx     = ptr + SEL_W'(gi);
            assign rot[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        winner = ptr;
        any    = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                winner = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_mux_arbiter.sv
// Arbiter sharing the 4:1 alu_multiplex path: grant, capture MUX_Y, present it with valid/ready.
// ALU_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise requester 0 always ranks highest.
module alu_mux_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [SEL_W-1:0] S,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] ACK,
    input  logic [W-1:0]     MUX_Y,
    output logic [W-1:0]     Y,
    output logic             Y_VALID,
    input  logic             Y_READY
);

    state_t           state_reg;
    logic [SEL_W-1:0] s_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [W-1:0]     y_reg;
    logic             y_valid_reg;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic             any_req;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_reg;

    // The committed winner is held in s_reg, so the pointer advances past it on capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg <= '0;
        end else if (state_reg == SEL) begin
            ptr_reg <= s_reg + SEL_W'(1);
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    rr_pick u_pick (
        .req    (REQ),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_req)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            s_reg       <= '0;
            gnt_reg     <= '0;
            ack_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        s_reg     <= winner;
                        gnt_reg   <= onehot(winner);
                        state_reg <= SEL;
                    end
                end
                SEL: begin
                    // Grant is committed here; REQ is no longer consulted
                    y_reg       <= MUX_Y;
                    y_valid_reg <= 1'b1;
                    ack_reg     <= gnt_reg;
                    gnt_reg     <= '0;
                    state_reg   <= VALID;
                end
                VALID: begin
                    if (Y_READY) begin
                        y_valid_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign S       = s_reg;
    assign GNT     = gnt_reg;
    assign ACK     = ack_reg;
    assign Y       = y_reg;
    assign Y_VALID = y_valid_reg;

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Testbench for alu_mux_arbiter: vector table of transfers plus hand-written corner sequences.
module tb_alu_mux_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = '0;
    logic [1:0] S;
    logic [3:0] GNT;
    logic [3:0] ACK;
    logic [7:0] MUX_Y;
    logic [7:0] Y;
    logic       Y_VALID;
    logic       Y_READY = 1'b0;

    logic [7:0] mux_in [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] win;
        logic [7:0] data;
    } sb_rec_t;

    sb_rec_t sb_q[$];

    typedef struct {
        logic [3:0] req;
        logic [7:0] data;
        logic [1:0] win_fixed;
        logic [1:0] win_rr;
    } vec_t;

    vec_t vecs [8];

    alu_mux_arbiter #(.W(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .S       (S),
        .GNT     (GNT),
        .ACK     (ACK),
        .MUX_Y   (MUX_Y),
        .Y       (Y),
        .Y_VALID (Y_VALID),
        .Y_READY (Y_READY)
    );

    // Behavioural stand-in for the separate alu_multiplex instance
    assign MUX_Y = mux_in[S];

    always #5 CLK = ~CLK;

    function automatic logic [3:0] oh(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard consumer: every ACK pulse must match the oldest pending transfer
    always @(posedge CLK) begin
        #2;
        if (ACK != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(ACK), 32'h0);
            end else begin
                sb_rec_t r;
                r = sb_q.pop_front();
                check("sb_ack", 32'(ACK), 32'(oh(r.win)));
                check("sb_y", 32'(Y), 32'(r.data));
            end
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        Y_READY = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic set_mux(input logic [1:0] win, input logic [7:0] data);
        for (int i = 0; i < 4; i++) begin
            mux_in[i] = (i == 32'(win)) ? data : ~data;
        end
    endtask

    // Full transfer from IDLE with REQ withdrawn in SEL and Y_READY raised after capture
    task automatic run_xfer(input logic [3:0] req, input logic [7:0] data,
                            input logic [1:0] win, input string tag);
        set_mux(win, data);
        sb_q.push_back('{win: win, data: data});
        REQ = req;
        Y_READY = 1'b0;
        @(posedge CLK); #1;
        check({tag, "_s"}, 32'(S), 32'(win));
        check({tag, "_gnt"}, 32'(GNT), 32'(oh(win)));
        check({tag, "_nvalid"}, 32'(Y_VALID), 32'h0);
        REQ = '0;
        @(posedge CLK); #1;
        check({tag, "_valid"}, 32'(Y_VALID), 32'h1);
        check({tag, "_gnt_clr"}, 32'(GNT), 32'h0);
        Y_READY = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_done"}, 32'(Y_VALID), 32'h0);
        check({tag, "_ack_clr"}, 32'(ACK), 32'h0);
        Y_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_win;
        logic [1:0] rr_order [5];
        int grants;
        int cycles;

        for (int i = 0; i < 4; i++) mux_in[i] = '0;

        // Sequential transfers; expected winners for each build from the pointer history
        vecs[0] = '{req: 4'b0100, data: 8'hA5, win_fixed: 2'd2, win_rr: 2'd2};
        vecs[1] = '{req: 4'b1001, data: 8'h11, win_fixed: 2'd0, win_rr: 2'd3};
        vecs[2] = '{req: 4'b1001, data: 8'h22, win_fixed: 2'd0, win_rr: 2'd0};
        vecs[3] = '{req: 4'b1111, data: 8'h33, win_fixed: 2'd0, win_rr: 2'd1};
        vecs[4] = '{req: 4'b0010, data: 8'h44, win_fixed: 2'd1, win_rr: 2'd1};
        vecs[5] = '{req: 4'b1010, data: 8'h55, win_fixed: 2'd1, win_rr: 2'd3};
        vecs[6] = '{req: 4'b0110, data: 8'h66, win_fixed: 2'd1, win_rr: 2'd1};
        vecs[7] = '{req: 4'b0011, data: 8'h77, win_fixed: 2'd0, win_rr: 2'd0};

        do_reset();
        check("rst_s", 32'(S), 32'h0);
        check("rst_gnt", 32'(GNT), 32'h0);
        check("rst_ack", 32'(ACK), 32'h0);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_valid", 32'(Y_VALID), 32'h0);

        for (int v = 0; v < 8; v++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_win = vecs[v].win_rr;
`else
            exp_win = vecs[v].win_fixed;
`endif
            run_xfer(vecs[v].req, vecs[v].data, exp_win, $sformatf("vec%0d", v));
        end

        // Back-pressure: hold 8'h3C for 5 cycles while a new request waits
        set_mux(2'd3, 8'h3C);
        sb_q.push_back('{win: 2'd3, data: 8'h3C});
        REQ = 4'b1000;
        @(posedge CLK); #1;
        REQ = '0;
        @(posedge CLK); #1;
        REQ = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_y_c%0d", c), 32'(Y), 32'h3C);
            check($sformatf("bp_valid_c%0d", c), 32'(Y_VALID), 32'h1);
            check($sformatf("bp_gnt_c%0d", c), 32'(GNT), 32'h0);
            @(posedge CLK); #1;
        end
        Y_READY = 1'b1;
        set_mux(2'd0, 8'hC3);
        sb_q.push_back('{win: 2'd0, data: 8'hC3});
        @(posedge CLK); #1;
        Y_READY = 1'b0;
        check("bp_released", 32'(Y_VALID), 32'h0);
        check("bp_no_early_gnt", 32'(GNT), 32'h0);
        @(posedge CLK); #1;
        check("bp_gnt_new", 32'(GNT), 32'h1);
        check("bp_s_new", 32'(S), 32'h0);
        REQ = '0;
        @(posedge CLK); #1;
        Y_READY = 1'b1;
        @(posedge CLK); #1;
        Y_READY = 1'b0;

        // Reset while VALID: transfer to 2 leaves the rotating pointer at 3
        run_xfer(4'b0001, 8'h01, 2'd0, "pre_rst");
        set_mux(2'd2, 8'h5A);
        sb_q.push_back('{win: 2'd2, data: 8'h5A});
        REQ = 4'b0100;
        @(posedge CLK); #1;
        REQ = '0;
        @(posedge CLK); #1;
        check("rv_valid_before", 32'(Y_VALID), 32'h1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rv_valid", 32'(Y_VALID), 32'h0);
        check("rv_y", 32'(Y), 32'h0);
        check("rv_s", 32'(S), 32'h0);
        check("rv_gnt", 32'(GNT), 32'h0);
        check("rv_ack", 32'(ACK), 32'h0);
        run_xfer(4'b1010, 8'h99, 2'd1, "rv_ptr0");

        // Continuous contention: each requester drops REQ on its ACK and re-raises it
        do_reset();
`ifdef ALU_ARB_ROUND_ROBIN_EN
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        rr_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int i = 0; i < 4; i++) mux_in[i] = 8'(8'h10 + i);
        for (int g = 0; g < 5; g++) begin
            sb_q.push_back('{win: rr_order[g], data: 8'(8'h10 + 32'(rr_order[g]))});
        end
        Y_READY = 1'b1;
        REQ = 4'b1111;
        grants = 0;
        cycles = 0;
        while (grants < 5 && cycles < 60) begin
            @(posedge CLK); #1;
            cycles++;
            if (GNT != 4'b0000) begin
                check($sformatf("rr_grant%0d", grants), 32'(GNT), 32'(oh(rr_order[grants])));
                grants++;
            end
            if (ACK != 4'b0000) REQ = REQ & ~ACK;
            else                REQ = 4'b1111;
        end
        check("rr_grant_count", 32'(grants), 32'd5);
        REQ = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
        end
        Y_READY = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mux_arbiter.md
# alu_mux_arbiter

- Sequences and shares the 4:1 `alu_multiplex` data-select path among four requesters.
- Arbitrates pending requests, drives the mux select, and captures the selected word in an output register.
- Presents the captured word downstream with a valid/ready handshake.
- Sits between the requesting units and the ALU result consumer; the mux itself stays a separate instance.

## Interface
- W, default 8: data width of the mux output captured here.
- CLK  input  1  rising-edge clock, single clock domain.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  REQ[i]=1: requester i wants its word (mux input i) transferred.
- S  output  2  select to `alu_multiplex`, registered.
- GNT  output  4  one-hot, high during SEL for the winner.
- ACK  output  4  one-hot, one-cycle pulse: requester i's word was captured.
- MUX_Y  input  W  `alu_multiplex` output, sampled one cycle after S is updated.
- Y  output  W  captured word, stable while Y_VALID=1.
- Y_VALID  output  1  Y holds an unconsumed word.
- Y_READY  input  1  downstream accepts Y when Y_VALID & Y_READY.

## Operation
- States: IDLE, SEL, VALID. 2-bit priority pointer PTR.
- IDLE, REQ=0: hold.
- IDLE, REQ≠0: on the next edge:
  - pick the winner from REQ, searching upward from PTR with modulo-4 wrap;
  - S<=winner, GNT<=onehot(winner), go to SEL.
- SEL, on the next edge:
  - Y<=MUX_Y, Y_VALID<=1, ACK<=GNT, GNT<=0;
  - PTR<=winner+1 (mod 4; 3 wraps to 0); go to VALID.
- A grant is committed once in SEL: REQ dropping during SEL still completes the capture and the ACK.
- VALID: hold Y and Y_VALID. On an edge with Y_READY=1: Y_VALID<=0, go to IDLE.
- REQ is ignored outside IDLE. Requesters must drop REQ within the cycle ACK is high, or they are granted again.
- Y_READY while Y_VALID=0 has no effect.
- S retains its last value outside SEL; only GNT qualifies it.

## Timing
- Reset values: S=0, GNT=0, ACK=0, Y=0, Y_VALID=0, state IDLE, PTR=0.
- Latency: REQ seen in IDLE at edge k → GNT high in cycle k..k+1 → Y_VALID/ACK high after edge k+1.
- Minimum 3 cycles per transfer (IDLE, SEL, VALID with Y_READY=1).
- MUX_Y must settle within the one SEL cycle (combinational mux path).
- Reset mid-operation:
  - the in-flight transfer is abandoned;
  - no ACK is issued, Y_VALID=0;
  - PTR returns to 0.
- Simultaneous requests: exactly one winner per transfer. Under continuous contention, every requester is served within 4 transfers.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: rotating priority via PTR as above.
- Undefined:
  - fixed priority, requester 0 highest, 3 lowest;
  - PTR is not implemented and the search always starts at 0;
  - all other behaviour is identical.

## Structure
- Package `alu_arb_pkg`:
  - state enum (IDLE, SEL, VALID);
  - N_REQ=4, SEL_W=2;
  - onehot helper function.
- Sub-module `rr_pick`: purely combinational; inputs REQ[3:0] and PTR[1:0]; outputs winner[1:0] and any.
  - Under the fixed-priority build, PTR is tied to 0.
- The arbiter top holds the FSM, PTR, output register and handshake.

## Test plan
- Single request: REQ=4'b0100, MUX_Y=8'hA5, Y_READY=1.
  - S=2 and GNT=4'b0100 for one cycle;
  - then Y=8'hA5, Y_VALID=1, ACK=4'b0100 for one cycle;
  - back to IDLE 3 cycles after the request.
- Round-robin: REQ=4'b1111 held, with each requester dropping its REQ on its ACK and re-raising it.
  - Grant order is 0,1,2,3,0.
  - Fixed-priority build: requester 0 whenever it requests.
- Back-pressure: Y_READY=0 for 5 cycles after capture of 8'h3C.
  - Y stays 8'h3C and Y_VALID=1;
  - a new REQ=4'b0001 is not granted until the cycle after Y_READY=1.
- REQ withdrawn during SEL: REQ[1] drops in SEL.
  - ACK[1] still pulses and Y=MUX_Y is captured.
- Wrap: PTR=3 after a grant to 2, REQ=4'b1001.
  - Requester 3 is granted, then PTR=0, then requester 0.
- Reset in VALID: RST=1 for one cycle.
  - Next cycle: Y_VALID=0, Y=0, S=0, GNT=0, ACK=0;
  - with REQ=4'b1010, requester 1 is granted first (PTR=0).
